matmul_loop_sequencer: RTL
==========================

Name: matmul_loop_sequencer

Overview:
- Sequences one matrix product C[MxP] = A[MxN] * B[NxP] over separate row-major A, B and C memories and an external MAC unit.
- Walks the i/j/k loop nest (k innermost, then j, then i), one tuple per cycle. Issues read addresses and read enables, and emits aligned MAC clear/enable and C write strobes.
- Addresses are built incrementally from incrementing base registers; no multipliers.
- Sits between the top-level control FSM and the operand/result memories.

Parameters:
DIM_W, 8, width of each matrix dimension input and of the i/j/k counters
ADDR_W, 16, width of every address output; addresses wrap modulo 2^ADDR_W
RD_LAT, 2, read latency of the A/B memories in cycles (>=1)

Ports:
clk  input  1  clock, all logic on rising edge
rst  input  1  synchronous, active-high reset
start  input  1  begin a product; sampled only in IDLE
dim_m  input  DIM_W  rows of A and C
dim_n  input  DIM_W  cols of A / rows of B
dim_p  input  DIM_W  cols of B and C
stall  input  1  hold issue for this cycle (memory port borrowed)
addr_a  output  ADDR_W  A read address = i*N + k
addr_b  output  ADDR_W  B read address = k*P + j
rd_en  output  1  A and B read strobe for the current tuple
mac_en  output  1  MAC operand data valid this cycle
mac_clr  output  1  with mac_en: load product instead of accumulating (k==0)
addr_c  output  ADDR_W  C write address = i*P + j, aligned with wr_en_c
wr_en_c  output  1  write MAC result to C
busy  output  1  high from the cycle after start is accepted until done
done  output  1  one-cycle completion pulse

Behaviour:
- Reset: all outputs 0, state IDLE, counters, base registers and delay pipeline cleared. Reset takes effect on the next edge even mid-run. There is no partial writeback after reset.
- States:
  - IDLE: start=1 latches dims and goes to RUN. If any dim is 0, go to DONE instead.
  - RUN: each non-stalled cycle issues the tuple (i,j,k) with rd_en=1. stall=1 gives rd_en=0 and freezes counters and addresses. After issuing the last tuple (M-1,P-1,N-1), go to DRAIN.
  - DRAIN: wait RD_LAT+1 cycles for the pipeline to empty, then go to DONE.
  - DONE: done=1 and busy=0 for one cycle, then IDLE.
- busy=1 in RUN and DRAIN. start is ignored outside IDLE.
- Counters, with k innermost:
  - k increments each issue.
  - At k==N-1: k wraps to 0 and j increments.
  - At j==P-1 (with k wrap): j wraps to 0 and i increments.
- Address registers, all updated on issue:
  - addr_a = rowA + k. rowA += N when i advances.
  - addr_b = kB + j. kB += P on every k step and resets to 0 when k wraps.
  - cRow += P when i advances. The write address is cRow + j.
- Tags: a tuple's tag {valid, first=(k==0), last=(k==N-1), c_addr} enters a shift register of depth RD_LAT and advances every cycle, with bubbles inserted while stalled.
  - mac_en and mac_clr assert exactly RD_LAT cycles after the matching rd_en.
  - wr_en_c and addr_c assert RD_LAT+1 cycles after the rd_en of a last tuple (MAC result registered one cycle).
- Latency: start accepted at edge 0 puts the first issue in cycle 1. With no stalls:
  - last issue in cycle MNP
  - last wr_en_c in cycle MNP+RD_LAT+1
  - done in cycle MNP+RD_LAT+2
  - each stall cycle adds 1
- N==1: every tuple is both first and last, so mac_clr and wr_en_c fire for each tuple.
- Dims are held internally; changing dim inputs during RUN has no effect.
- Address arithmetic is unsigned ADDR_W-bit with wrap; sizing memories is the caller's job.

Decomposition:
- Shared package: state encoding (IDLE, RUN, DRAIN, DONE) and the tag record layout {valid, first, last, c_addr}.
- One sub-module, seq_tag_delay: a RD_LAT-deep parameterised shift register for the tags.
- Counters and base registers stay in the top module.

Test Plan:
- M=N=P=2, RD_LAT=2, start at edge 0:
  - rd_en in cycles 1-8, addr_a 0,1,0,1,2,3,2,3 and addr_b 0,2,1,3,0,2,1,3
  - mac_clr in cycles 3,5,7,9
  - wr_en_c in cycles 5,7,9,11 with addr_c 0,1,2,3
  - done in cycle 12
- M=N=P=1: rd_en cycle 1, mac_en+mac_clr cycle 3, wr_en_c addr_c=0 cycle 4, done cycle 5, busy high in cycles 1-4.
- dim_n=0 with start: no rd_en, mac_en or wr_en_c; done in cycle 1; busy never high.
- 2x2x2 with stall high in cycles 3-4:
  - addresses hold at the cycle-3 tuple (addr_a=0, addr_b=1)
  - mac_en has a 2-cycle bubble
  - done in cycle 14
  - start pulsed in cycle 6 is ignored (no restart after done)
- rst=1 at cycle 4 of a 2x2x2 run: from cycle 5 all outputs 0 and state IDLE; a new start gives the full fresh sequence from addr_a=0, addr_b=0.
- M=3, N=1, P=2: wr_en_c each issue (cycles 4-9), addr_c 0..5, mac_clr on every mac_en.

Source files
------------

// File: rtl/matmul_loop_sequencer_pkg.sv
// Shared types for the matmul loop sequencer: the FSM state encoding and the
// layout of the per-tuple tag that travels alongside the memory read latency.
package matmul_loop_sequencer_pkg;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_RUN,
    ST_DRAIN,
    ST_DONE
  } seq_state_t;

  // A tag is {tag_flags_t, c_addr}; c_addr width follows the sequencer's ADDR_W.
  typedef struct packed {
    logic valid;
    logic first;
    logic last;
  } tag_flags_t;

  localparam int unsigned TAG_FLAGS_W = $bits(tag_flags_t);

endpackage

// File: rtl/matmul_loop_sequencer_tag_delay.sv
// Fixed-depth shift register carrying tuple tags so MAC/writeback strobes line
// up with operand data returning from the A/B memories.
module seq_tag_delay #(
  parameter int unsigned DEPTH = 2,
  parameter int unsigned WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] dout
);

  logic [WIDTH-1:0] stage_q [DEPTH];
  logic [WIDTH-1:0] stage_d [DEPTH];

  always_comb begin
    stage_d[0] = din;
    for (int unsigned s = 1; s < DEPTH; s++) begin
      stage_d[s] = stage_q[s-1];
    end
  end

  always_ff @(posedge clk) begin
    for (int unsigned s = 0; s < DEPTH; s++) begin
      if (rst) stage_q[s] <= '0;
      else     stage_q[s] <= stage_d[s];
    end
  end

  assign dout = stage_q[DEPTH-1];

endmodule

// File: rtl/matmul_loop_sequencer.sv
// i/j/k loop-nest sequencer for C = A * B: issues A/B read addresses one tuple
// per cycle and emits aligned MAC clear/enable and C write strobes.
module matmul_loop_sequencer
  import matmul_loop_sequencer_pkg::*;
#(
  parameter int unsigned DIM_W  = 8,
  parameter int unsigned ADDR_W = 16,
  parameter int unsigned RD_LAT = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [DIM_W-1:0]  dim_m,
  input  logic [DIM_W-1:0]  dim_n,
  input  logic [DIM_W-1:0]  dim_p,
  input  logic              stall,
  output logic [ADDR_W-1:0] addr_a,
  output logic [ADDR_W-1:0] addr_b,
  output logic              rd_en,
  output logic              mac_en,
  output logic              mac_clr,
  output logic [ADDR_W-1:0] addr_c,
  output logic              wr_en_c,
  output logic              busy,
  output logic              done
);

  localparam int unsigned TAG_W  = TAG_FLAGS_W + ADDR_W;
  localparam int unsigned DCNT_W = $clog2(RD_LAT + 1) + 1;

  seq_state_t state_q, state_d;
  logic [DIM_W-1:0]  dim_m_q, dim_m_d, dim_n_q, dim_n_d, dim_p_q, dim_p_d;
  logic [DIM_W-1:0]  i_q, i_d, j_q, j_d, k_q, k_d;
  logic [ADDR_W-1:0] row_a_q, row_a_d, kb_q, kb_d, c_row_q, c_row_d;
  logic [DCNT_W-1:0] drain_q, drain_d;
  logic              wr_en_c_q, wr_en_c_d;
  logic [ADDR_W-1:0] addr_c_q, addr_c_d;

  logic              issue, k_last, j_last, i_last;
  tag_flags_t        flags_in, flags_out;
  logic [ADDR_W-1:0] c_in, c_out;
  logic [TAG_W-1:0]  tag_in, tag_out;

  assign issue  = (state_q == ST_RUN) && !stall;
  assign k_last = (k_q == dim_n_q - DIM_W'(1));
  assign j_last = (j_q == dim_p_q - DIM_W'(1));
  assign i_last = (i_q == dim_m_q - DIM_W'(1));

  always_comb begin
    state_d = state_q;
    dim_m_d = dim_m_q;
    dim_n_d = dim_n_q;
    dim_p_d = dim_p_q;
    i_d     = i_q;
    j_d     = j_q;
    k_d     = k_q;
    row_a_d = row_a_q;
    kb_d    = kb_q;
    c_row_d = c_row_q;
    drain_d = drain_q;

    case (state_q)
      ST_IDLE: begin
        if (start) begin
          dim_m_d = dim_m;
          dim_n_d = dim_n;
          dim_p_d = dim_p;
          if (dim_m == '0 || dim_n == '0 || dim_p == '0) state_d = ST_DONE;
          else                                           state_d = ST_RUN;
        end
      end
      ST_RUN: begin
        if (issue) begin
          if (!k_last) begin
            k_d  = k_q + DIM_W'(1);
            kb_d = kb_q + ADDR_W'(dim_p_q);
          end else begin
            k_d  = '0;
            kb_d = '0;
            if (!j_last) begin
              j_d = j_q + DIM_W'(1);
            end else begin
              j_d     = '0;
              i_d     = i_q + DIM_W'(1);
              row_a_d = row_a_q + ADDR_W'(dim_n_q);
              c_row_d = c_row_q + ADDR_W'(dim_p_q);
            end
          end
          // Final tuple: park everything at zero so IDLE presents zero addresses.
          if (k_last && j_last && i_last) begin
            state_d = ST_DRAIN;
            i_d     = '0;
            row_a_d = '0;
            c_row_d = '0;
            drain_d = '0;
          end
        end
      end
      ST_DRAIN: begin
        if (drain_q == DCNT_W'(RD_LAT)) state_d = ST_DONE;
        else                            drain_d = drain_q + DCNT_W'(1);
      end
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    flags_in.valid = issue;
    flags_in.first = issue && (k_q == '0);
    flags_in.last  = issue && k_last;
    c_in           = issue ? (c_row_q + ADDR_W'(j_q)) : '0;
    tag_in         = {flags_in, c_in};
    flags_out      = tag_flags_t'(tag_out[TAG_W-1 -: TAG_FLAGS_W]);
    c_out          = tag_out[ADDR_W-1:0];
    wr_en_c_d      = flags_out.valid && flags_out.last;
    addr_c_d       = wr_en_c_d ? c_out : '0;
  end

  seq_tag_delay #(
    .DEPTH(RD_LAT),
    .WIDTH(TAG_W)
  ) u_tag_delay (
    .clk  (clk),
    .rst  (rst),
    .din  (tag_in),
    .dout (tag_out)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= ST_IDLE;
      dim_m_q   <= '0;
      dim_n_q   <= '0;
      dim_p_q   <= '0;
      i_q       <= '0;
      j_q       <= '0;
      k_q       <= '0;
      row_a_q   <= '0;
      kb_q      <= '0;
      c_row_q   <= '0;
      drain_q   <= '0;
      wr_en_c_q <= 1'b0;
      addr_c_q  <= '0;
    end else begin
      state_q   <= state_d;
      dim_m_q   <= dim_m_d;
      dim_n_q   <= dim_n_d;
      dim_p_q   <= dim_p_d;
      i_q       <= i_d;
      j_q       <= j_d;
      k_q       <= k_d;
      row_a_q   <= row_a_d;
      kb_q      <= kb_d;
      c_row_q   <= c_row_d;
      drain_q   <= drain_d;
      wr_en_c_q <= wr_en_c_d;
      addr_c_q  <= addr_c_d;
    end
  end

  assign rd_en   = issue;
  assign addr_a  = row_a_q + ADDR_W'(k_q);
  assign addr_b  = kb_q + ADDR_W'(j_q);
  assign mac_en  = flags_out.valid;
  assign mac_clr = flags_out.valid && flags_out.first;
  assign wr_en_c = wr_en_c_q;
  assign addr_c  = addr_c_q;
  assign busy    = (state_q == ST_RUN) || (state_q == ST_DRAIN);
  assign done    = (state_q == ST_DONE);

endmodule
